// File: rtl/bypass_scoreboard_pkg.sv
// Shared constants for the bypass scoreboard: default widths and stage indices.
// Optional feature macro: BYPASS_PERF_EN (performance counters).
package bypass_scoreboard_pkg;

    localparam int DEF_NUM_RD = 2;
    localparam int DEF_DEPTH  = 3;
    localparam int DEF_AW     = 5;
    localparam int DEF_DW     = 32;

    typedef enum int {
        STG_EX  = 0,
        STG_MEM = 1,
        STG_WB  = 2
    } stg_e;

    function automatic int sw_of(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bypass_scoreboard_port.sv
// One read port: youngest-producer priority select with not-yet-ready hazard.
// Optional feature macro: BYPASS_PERF_EN (handled in the top).
module bypass_port
    import bypass_scoreboard_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW,
    parameter int SW    = sw_of(DEF_DEPTH)
) (
    input  logic                       rd_en,
    input  logic [AW-1:0]              rd_addr,
    input  logic [DW-1:0]              rf_rdata,
    input  logic [DEPTH-1:0]           tag_v,
    input  logic [DEPTH-1:0]           tag_we,
    input  logic [DEPTH-1:0][AW-1:0]   tag_waddr,
    input  logic [DEPTH-1:0][SW-1:0]   tag_rs,
    input  logic [DEPTH-1:0][DW-1:0]   stg_wdata,
    output logic [DW-1:0]              rd_data,
    output logic                       hazard,
    output logic                       fwd
);

    // Walk oldest to youngest so the youngest match overwrites everything older.
    always_comb begin
        rd_data = rf_rdata;
        hazard  = 1'b0;
        fwd     = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (rd_en && tag_v[k] && tag_we[k] && tag_waddr[k] == rd_addr && rd_addr != '0) begin
                if (k >= int'(tag_rs[k])) begin
                    rd_data = stg_wdata[k];
                    hazard  = 1'b0;
                    fwd     = 1'b1;
                end else begin
                    rd_data = rf_rdata;
                    hazard  = 1'b1;
                    fwd     = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/bypass_scoreboard.sv
// Forwarding/interlock unit: tag pipeline shadowing DEPTH post-decode stages.
// Optional feature macro: BYPASS_PERF_EN adds perf_stall_cnt / perf_fwd_cnt.
module bypass_scoreboard
    import bypass_scoreboard_pkg::*;
#(
    parameter int NUM_RD = DEF_NUM_RD,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AW     = DEF_AW,
    parameter int DW     = DEF_DW,
    parameter int SW     = sw_of(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   iss_fire,
    input  logic                   iss_rf_we,
    input  logic [AW-1:0]          iss_rf_waddr,
    input  logic [SW-1:0]          iss_rdy_stg,
    input  logic [DEPTH-1:0]       stg_fire,
    input  logic [DEPTH-1:0]       flush,
    input  logic [DEPTH*DW-1:0]    stg_rf_wdata,
    input  logic [NUM_RD-1:0]      rd_en,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    input  logic [NUM_RD*DW-1:0]   rf_rdata,
    output logic [NUM_RD*DW-1:0]   rd_data,
    output logic                   id_stall,
`ifdef BYPASS_PERF_EN
    output logic [31:0]            perf_stall_cnt,
    output logic [31:0]            perf_fwd_cnt,
`endif
    output logic                   busy
);

    typedef struct packed {
        logic          v;
        logic          we;
        logic [AW-1:0] waddr;
        logic [SW-1:0] rs;
    } tag_t;

    tag_t [DEPTH-1:0] tag_q, tag_d, src_tag;
    logic [DEPTH-1:0] mv;
    logic             busy_q, busy_d;

    logic [DEPTH-1:0]           tag_v, tag_we;
    logic [DEPTH-1:0][AW-1:0]   tag_waddr;
    logic [DEPTH-1:0][SW-1:0]   tag_rs;
    logic [DEPTH-1:0][DW-1:0]   stg_wdata_a;
    logic [NUM_RD-1:0][AW-1:0]  rd_addr_a;
    logic [NUM_RD-1:0][DW-1:0]  rf_rdata_a, rd_data_a;
    logic [NUM_RD-1:0]          hazard, fwd;

    assign stg_wdata_a = stg_rf_wdata;
    assign rd_addr_a   = rd_addr;
    assign rf_rdata_a  = rf_rdata;
    assign rd_data     = rd_data_a;

    // r0 writes are stored as non-writing so they can never match.
    assign src_tag[STG_EX] = '{v: 1'b1, we: iss_rf_we && iss_rf_waddr != '0,
                               waddr: iss_rf_waddr, rs: iss_rdy_stg};
    assign mv[STG_EX]      = iss_fire;

    for (genvar k = 1; k < DEPTH; k++) begin : g_src
        assign src_tag[k] = tag_q[k-1];
        assign mv[k]      = stg_fire[k-1];
    end

    always_comb begin
        tag_d = tag_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (mv[k])
                tag_d[k] = src_tag[k];
            else if (stg_fire[k])
                tag_d[k].v = 1'b0;
            if (flush[k])
                tag_d[k].v = 1'b0;
        end
        busy_d = 1'b0;
        for (int k = 0; k < DEPTH; k++)
            busy_d = busy_d | tag_d[k].v;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) tag_q[k] <= '0;
            busy_q <= 1'b0;
        end else begin
            tag_q  <= tag_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

    for (genvar k = 0; k < DEPTH; k++) begin : g_tag
        assign tag_v[k]     = tag_q[k].v;
        assign tag_we[k]    = tag_q[k].we;
        assign tag_waddr[k] = tag_q[k].waddr;
        assign tag_rs[k]    = tag_q[k].rs;
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        bypass_port #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .SW(SW)) u_port (
            .rd_en     (rd_en[i]),
            .rd_addr   (rd_addr_a[i]),
            .rf_rdata  (rf_rdata_a[i]),
            .tag_v     (tag_v),
            .tag_we    (tag_we),
            .tag_waddr (tag_waddr),
            .tag_rs    (tag_rs),
            .stg_wdata (stg_wdata_a),
            .rd_data   (rd_data_a[i]),
            .hazard    (hazard[i]),
            .fwd       (fwd[i])
        );
    end

    assign id_stall = |hazard;

`ifdef BYPASS_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, id_stall};
        fwd_cnt_d   = fwd_cnt_q + {31'd0, |fwd};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_fwd_cnt   = fwd_cnt_q;
`else
    logic unused_fwd;
    assign unused_fwd = |fwd;
`endif

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Self-checking bench for bypass_scoreboard: directed cases plus randomized traffic vs. a model.
module tb_bypass_scoreboard;

    localparam int NUM_RD = 2;
    localparam int DEPTH  = 3;
    localparam int AW     = 5;
    localparam int DW     = 32;
    localparam int SW     = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  iss_fire, iss_rf_we;
    logic [AW-1:0]         iss_rf_waddr;
    logic [SW-1:0]         iss_rdy_stg;
    logic [DEPTH-1:0]      stg_fire, flush;
    logic [DEPTH*DW-1:0]   stg_rf_wdata;
    logic [NUM_RD-1:0]     rd_en;
    logic [NUM_RD*AW-1:0]  rd_addr;
    logic [NUM_RD*DW-1:0]  rf_rdata;
    logic [NUM_RD*DW-1:0]  rd_data;
    logic                  id_stall, busy;
`ifdef BYPASS_PERF_EN
    logic [31:0]           perf_stall_cnt, perf_fwd_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bypass_scoreboard #(.NUM_RD(NUM_RD), .DEPTH(DEPTH), .AW(AW), .DW(DW), .SW(SW)) dut (
        .clk(clk), .rst(rst), .iss_fire(iss_fire), .iss_rf_we(iss_rf_we),
        .iss_rf_waddr(iss_rf_waddr), .iss_rdy_stg(iss_rdy_stg), .stg_fire(stg_fire),
        .flush(flush), .stg_rf_wdata(stg_rf_wdata), .rd_en(rd_en), .rd_addr(rd_addr),
        .rf_rdata(rf_rdata), .rd_data(rd_data), .id_stall(id_stall),
`ifdef BYPASS_PERF_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt),
`endif
        .busy(busy)
    );

    // Behavioural model: what each stage holds, by issue order.
    bit m_v [DEPTH];
    bit m_we[DEPTH];
    int m_addr[DEPTH];
    int m_rs[DEPTH];
    int unsigned m_stall_cnt, m_fwd_cnt;
    bit f_stall, f_fwd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_out(output logic [NUM_RD*DW-1:0] rd, output bit stall, output bit any_fwd);
        stall = 0; any_fwd = 0;
        for (int i = 0; i < NUM_RD; i++) begin
            int a;
            bit found;
            a = int'(rd_addr[i*AW +: AW]);
            rd[i*DW +: DW] = rf_rdata[i*DW +: DW];
            found = 0;
            for (int k = 0; k < DEPTH; k++) begin
                if (!found && rd_en[i] && m_v[k] && m_we[k] && m_addr[k] == a && a != 0) begin
                    found = 1;
                    if (k >= m_rs[k]) begin
                        rd[i*DW +: DW] = stg_rf_wdata[k*DW +: DW];
                        any_fwd = 1;
                    end else
                        stall = 1;
                end
            end
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) m_v[k] = 0;
            m_stall_cnt = 0;
            m_fwd_cnt   = 0;
        end else begin
            bit ov[DEPTH]; bit owe[DEPTH]; int oa[DEPTH]; int ors[DEPTH];
            m_stall_cnt += f_stall ? 1 : 0;
            m_fwd_cnt   += f_fwd ? 1 : 0;
            ov = m_v; owe = m_we; oa = m_addr; ors = m_rs;
            for (int k = 0; k < DEPTH; k++) begin
                bit mvk;
                mvk = (k == 0) ? iss_fire : stg_fire[k-1];
                if (mvk) begin
                    if (k == 0) begin
                        m_v[0] = 1; m_we[0] = iss_rf_we && iss_rf_waddr != 0;
                        m_addr[0] = int'(iss_rf_waddr); m_rs[0] = int'(iss_rdy_stg);
                    end else begin
                        m_v[k] = ov[k-1]; m_we[k] = owe[k-1]; m_addr[k] = oa[k-1]; m_rs[k] = ors[k-1];
                    end
                end else if (stg_fire[k])
                    m_v[k] = 0;
                if (flush[k]) m_v[k] = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [NUM_RD*DW-1:0] e_rd;
        bit e_stall, e_fwd, e_busy;
        f_stall = 0; f_fwd = 0;
        if (!rst) begin
            model_out(e_rd, e_stall, e_fwd);
            e_busy = 0;
            for (int k = 0; k < DEPTH; k++) e_busy |= m_v[k];
            f_stall = e_stall; f_fwd = e_fwd;
            for (int i = 0; i < NUM_RD; i++)
                if (!e_stall) chk($sformatf("model_rd_data%0d", i), 64'(rd_data[i*DW +: DW]), 64'(e_rd[i*DW +: DW]));
            chk("model_id_stall", 64'(id_stall), 64'(e_stall));
            chk("model_busy", 64'(busy), 64'(e_busy));
`ifdef BYPASS_PERF_EN
            chk("model_perf_stall", 64'(perf_stall_cnt), 64'(m_stall_cnt));
            chk("model_perf_fwd", 64'(perf_fwd_cnt), 64'(m_fwd_cnt));
`endif
        end
    end

    task automatic idle();
        iss_fire = 0; iss_rf_we = 0; iss_rf_waddr = '0; iss_rdy_stg = '0;
        stg_fire = '0; flush = '0; stg_rf_wdata = '0;
        rd_en = '0; rd_addr = '0; rf_rdata = {32'h11, 32'h22};
    endtask

    task automatic nxt();
        @(posedge clk); #1; idle();
    endtask

    task automatic do_reset();
        rst = 1; nxt(); nxt(); rst = 0;
    endtask

    task automatic issue(input int a, input int rs);
        iss_fire = 1; iss_rf_we = 1; iss_rf_waddr = AW'(a); iss_rdy_stg = SW'(rs);
    endtask

    task automatic rd0(input int a);
        rd_en[0] = 1; rd_addr[AW-1:0] = AW'(a);
    endtask

    initial begin
        idle();
        do_reset();
        // reset state
        rd_en = 2'b11; rd_addr = {5'd5, 5'd3};
        @(negedge clk);
        chk("reset_rd_data", 64'(rd_data), 64'({32'h11, 32'h22}));
        chk("reset_stall", 64'(id_stall), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        // ALU forward from stage 0
        nxt(); issue(5, 0);
        nxt(); stg_rf_wdata[31:0] = 32'hAAAA; rd0(5);
        @(negedge clk);
        chk("alu_fwd", 64'(rd_data[31:0]), 64'h0000_AAAA);
        chk("alu_nostall", 64'(id_stall), 64'd0);
        // load-use
        nxt(); issue(7, 1); stg_fire = 3'b001;
        nxt(); rd0(7);
        @(negedge clk);
        chk("load_use_stall", 64'(id_stall), 64'd1);
        nxt(); stg_fire = 3'b011;
        nxt(); stg_rf_wdata[63:32] = 32'h1234; rd0(7);
        @(negedge clk);
        chk("load_fwd_mem", 64'(rd_data[31:0]), 64'h1234);
        chk("load_stall_drop", 64'(id_stall), 64'd0);
`ifdef BYPASS_PERF_EN
        chk("perf_stall_one", 64'(perf_stall_cnt), 64'd1);
`endif
        // youngest wins
        do_reset(); issue(4, 0);
        nxt(); issue(4, 0); stg_fire = 3'b001;
        nxt(); stg_fire = 3'b011;
        nxt(); stg_rf_wdata = {32'h5, 32'h9, 32'h0}; rd0(4); issue(4, 1);
        @(negedge clk);
        chk("youngest_wins", 64'(rd_data[31:0]), 64'h9);
        nxt(); stg_rf_wdata = {32'h5, 32'h9, 32'h0}; rd0(4);
        @(negedge clk);
        chk("young_unready_stall", 64'(id_stall), 64'd1);
        // r0 never forwarded
        do_reset(); issue(0, 0);
        nxt(); stg_rf_wdata[31:0] = 32'hFFFF; rd_en = 2'b01;
        @(negedge clk);
        chk("r0_rdata", 64'(rd_data[31:0]), 64'h22);
        chk("r0_nostall", 64'(id_stall), 64'd0);
        // flush kills the incoming tag
        do_reset(); issue(6, 1); flush = 3'b001;
        nxt(); rd0(6);
        @(negedge clk);
        chk("flush_nostall", 64'(id_stall), 64'd0);
        chk("flush_rdata", 64'(rd_data[31:0]), 64'h22);
        chk("flush_busy", 64'(busy), 64'd0);
        issue(9, 0);
        nxt();
        @(negedge clk);
        chk("busy_set", 64'(busy), 64'd1);
        rst = 1;
        nxt();
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 0;
        // randomized traffic with a legal fire pattern
        repeat (3000) begin
            nxt();
            rst = ($urandom_range(0, 199) == 0);
            stg_fire[DEPTH-1] = 1'($urandom);
            for (int k = DEPTH - 2; k >= 0; k--)
                if (!m_v[k+1] || stg_fire[k+1]) stg_fire[k] = 1'($urandom);
            if (!m_v[0] || stg_fire[0]) iss_fire = 1'($urandom);
            iss_rf_we    = ($urandom_range(0, 3) != 0);
            iss_rf_waddr = AW'($urandom_range(0, 7));
            iss_rdy_stg  = SW'($urandom_range(0, 1));
            for (int k = 0; k < DEPTH; k++) flush[k] = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < DEPTH; k++) stg_rf_wdata[k*DW +: DW] = $urandom;
            for (int i = 0; i < NUM_RD; i++) begin
                rd_en[i] = 1'($urandom);
                rd_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
                rf_rdata[i*DW +: DW] = $urandom;
            end
        end
        nxt();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
